instr_fetch_queue: RTL and testbench

Fetch stage directly downstream of the program counter.
- Takes each PC address, issues a read to the synchronous instruction memory (1-cycle read latency), and tags the returned word with its PC.
- Buffers fetched words in a small in-order queue and presents them to decode over a valid/ready handshake.
- Absorbs decode stalls and supports a flush for branch redirects.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_sync_fifo.sv | 72 +++++++
 rtl/instr_fetch_queue.sv | 104 ++++++++++
 tb/tb_instr_fetch_queue.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned DEFAULT_ADDR_WIDTH  = 12;
   localparam int unsigned DEFAULT_INSTR_WIDTH = 32;
   localparam int unsigned DEFAULT_DEPTH       = 4;

   // One fetched instruction tagged with the PC it was read from.
   typedef struct packed {
      logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
      logic [DEFAULT_INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

   // Value shown on the decode interface while nothing has been fetched.
   localparam logic [DEFAULT_INSTR_WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_sync_fifo.sv
// In-order register-array FIFO with synchronous clear; pointers wrap modulo DEPTH.
module fetch_sync_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter type         entry_t   = fetch_entry_t,
   parameter entry_t      RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   input  entry_t                     wdata_i,
   output entry_t                     rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   // Pointer and occupancy update; clear wins over any push/pop.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) wptr_d = wptr_q + PW'(1);
         if (pop_i)  rptr_d = rptr_q + PW'(1);
         if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
         end else if (!push_i && pop_i) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Storage and pointer state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= RESET_VAL;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Head entry and status straight from registers.
   always_comb begin
      rdata_o = mem_q[rptr_q];
      count_o = count_q;
      full_o  = (count_q == CW'(DEPTH));
      empty_o = (count_q == '0);
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues PC reads to a 1-cycle synchronous instruction memory, tags the returned
// word with its PC and queues it for decode behind a valid/ready handshake.
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
   parameter int unsigned DEPTH       = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_WIDTH-1:0]      pc_in,
   input  logic                       pc_valid,
   output logic                       pc_ready,
   output logic                       imem_en,
   output logic [ADDR_WIDTH-1:0]      imem_addr,
   input  logic [INSTR_WIDTH-1:0]     imem_rdata,
   input  logic                       flush,
   output logic                       if_valid,
   input  logic                       if_ready,
   output logic [INSTR_WIDTH-1:0]     if_instr,
   output logic [ADDR_WIDTH-1:0]      if_pc,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  pc;
      logic [INSTR_WIDTH-1:0] instr;
   } entry_t;

   localparam entry_t RESET_ENTRY = '{pc: '0, instr: INSTR_WIDTH'(NOP_INSTR)};

   logic                  inflight_q, inflight_d;
   logic                  squash_q, squash_d;
   logic [ADDR_WIDTH-1:0] tag_pc_q, tag_pc_d;
   logic                  accept;
   logic [CW:0]           credit_used;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   entry_t                fifo_wdata, fifo_rdata;

   // Credit check counts the outstanding read too, and ignores a same-cycle pop so that
   // if_ready never reaches pc_ready combinationally.
   always_comb begin
      credit_used = {1'b0, count} + (CW+1)'(inflight_q);
      pc_ready    = !reset && !flush && (credit_used < (CW+1)'(DEPTH));
      accept      = pc_valid && pc_ready;
      imem_en     = accept;
      imem_addr   = accept ? pc_in : '0;
   end

   // Next state of the single outstanding-read tracker.
   always_comb begin
      inflight_d = accept;
      tag_pc_d   = accept ? pc_in : tag_pc_q;
      squash_d   = flush;
   end

   // Queue control and decode-side outputs; flush overrides push and pop.
   always_comb begin
      fifo_push  = inflight_q && !squash_q && !flush;
      fifo_pop   = if_valid && if_ready && !flush;
      fifo_wdata = '{pc: tag_pc_q, instr: imem_rdata};
      if_valid   = !fifo_empty;
      if_pc      = fifo_rdata.pc;
      if_instr   = fifo_rdata.instr;
   end

   // In-flight, PC tag and squash registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_q <= 1'b0;
         squash_q   <= 1'b0;
         tag_pc_q   <= '0;
      end else begin
         inflight_q <= inflight_d;
         squash_q   <= squash_d;
         tag_pc_q   <= tag_pc_d;
      end
   end

   fetch_sync_fifo #(
      .DEPTH     (DEPTH),
      .entry_t   (entry_t),
      .RESET_VAL (RESET_ENTRY)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .clear_i (flush),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .count_o (count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // The credit rule must make an overflowing push unreachable.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: accepted PCs are predicted into a queue, a monitor
// pops and compares whenever decode takes an instruction.
module tb_instr_fetch_queue;

   localparam int unsigned AW    = 12;
   localparam int unsigned IW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] pc_in = '0;
   logic          pc_valid = 1'b0;
   logic          pc_ready;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata = '0;
   logic          flush = 1'b0;
   logic          if_valid;
   logic          if_ready = 1'b0;
   logic [IW-1:0] if_instr;
   logic [AW-1:0] if_pc;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   // Expected stream: every accepted, not yet consumed and not flushed PC in order.
   logic [AW-1:0] exp_q[$];

   instr_fetch_queue #(
      .ADDR_WIDTH  (AW),
      .INSTR_WIDTH (IW),
      .DEPTH       (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_in      (pc_in),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .imem_en    (imem_en),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .flush      (flush),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .count      (count)
   );

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return 32'h1000_0000 + {{(IW-AW){1'b0}}, a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || if_valid) && n < max) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", (n < max), 1'b1);
   endtask

   // Instruction memory: 1-cycle read latency, garbage when not enabled.
   always @(posedge clk) imem_rdata <= imem_en ? mem_word(imem_addr) : $urandom();

   // Predictor: record what the bench issued, apply at the following clock edge.
   logic          s_acc = 1'b0;
   logic          s_flush = 1'b0;
   logic [AW-1:0] s_pc = '0;
   always @(negedge clk) begin
      s_acc   <= pc_valid && pc_ready;
      s_flush <= flush;
      s_pc    <= pc_in;
   end
   always @(posedge clk) begin
      if (reset || s_flush) exp_q.delete();
      else if (s_acc) exp_q.push_back(s_pc);
   end

   // Monitor: occupancy/credit rules, memory interface, hold stability and in-order delivery.
   logic          prev_acc = 1'b0;
   logic          prev_hold = 1'b0;
   logic [AW-1:0] hold_pc = '0;
   logic [IW-1:0] hold_instr = '0;
   logic          m_acc;
   int            exp_cnt;
   logic [AW-1:0] e_pc;
   always @(negedge clk) begin
      if (reset) begin
         prev_acc  <= 1'b0;
         prev_hold <= 1'b0;
      end else begin
         m_acc   = pc_valid && pc_ready;
         exp_cnt = exp_q.size() - int'(prev_acc);
         check("count", count, exp_cnt);
         check("if_valid", if_valid, (exp_cnt != 0));
         check("pc_ready", pc_ready, (!flush && exp_q.size() < DEPTH));
         check("imem_en", imem_en, m_acc);
         check("imem_addr", imem_addr, m_acc ? pc_in : '0);
         if (prev_hold) begin
            check("hold_pc", if_pc, hold_pc);
            check("hold_instr", if_instr, hold_instr);
         end
         if (if_valid && if_ready && !flush) begin
            check("pop_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
               e_pc = exp_q.pop_front();
               check("pop_pc", if_pc, e_pc);
               check("pop_instr", if_instr, mem_word(e_pc));
            end
         end
         prev_acc   <= m_acc;
         prev_hold  <= if_valid && !if_ready && !flush;
         hold_pc    <= if_pc;
         hold_instr <= if_instr;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   logic acc_now;
   int   n_acc;
   initial begin
      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_if_valid", if_valid, 1'b0);
      check("rst_count", count, 0);
      check("rst_if_pc", if_pc, 0);
      check("rst_if_instr", if_instr, 0);
      check("rst_imem_en", imem_en, 1'b0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", pc_ready, 1'b1);

      // Streaming pc 0..3 with decode always ready.
      step();
      if_ready = 1'b1;
      pc_valid = 1'b1;
      pc_in    = 12'd0;
      step();
      pc_in = 12'd1;
      @(negedge clk);
      check("lat_n1_valid", if_valid, 1'b0);
      step();
      pc_in = 12'd2;
      @(negedge clk);
      check("lat_n2_valid", if_valid, 1'b1);
      check("lat_n2_pc", if_pc, 12'd0);
      step();
      pc_in = 12'd3;
      @(negedge clk);
      check("stream_pc1", if_pc, 12'd1);
      step();
      pc_valid = 1'b0;
      @(negedge clk);
      check("stream_pc2", if_pc, 12'd2);
      step();
      @(negedge clk);
      check("stream_pc3", if_pc, 12'd3);
      check("stream_instr3", if_instr, 32'h1000_0003);
      wait_drain(20);

      // Stalled decode with a continuous request stream.
      step();
      if_ready = 1'b0;
      pc_valid = 1'b1;
      pc_in    = 12'h010;
      n_acc    = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 4) begin
            check("credit_ready_low", pc_ready, 1'b0);
            check("credit_count3", count, 3);
         end
         if (i == 5) begin
            check("full_count4", count, 4);
            check("full_head_pc", if_pc, 12'h010);
         end
         acc_now = pc_valid && pc_ready;
         step();
         if (acc_now) begin
            n_acc++;
            pc_in = pc_in + 12'd1;
         end
      end
      check("accepted_4", n_acc, 4);
      pc_valid = 1'b0;

      // One pop from full: credit returns only the following cycle.
      if_ready = 1'b1;
      @(negedge clk);
      check("pop_cycle_ready", pc_ready, 1'b0);
      step();
      if_ready = 1'b0;
      @(negedge clk);
      check("after_pop_ready", pc_ready, 1'b1);
      check("after_pop_count", count, 3);
      step();
      if_ready = 1'b1;
      wait_drain(30);

      // Flush with pc 5,6 queued and pc 7 in flight.
      step();
      if_ready = 1'b0;
      pc_valid = 1'b1;
      pc_in    = 12'd5;
      step();
      pc_in = 12'd6;
      step();
      pc_in = 12'd7;
      step();
      pc_valid = 1'b0;
      flush    = 1'b1;
      @(negedge clk);
      check("flush_cycle_ready", pc_ready, 1'b0);
      check("pre_flush_count", count, 2);
      step();
      flush    = 1'b0;
      if_ready = 1'b1;
      pc_valid = 1'b1;
      pc_in    = 12'h020;
      @(negedge clk);
      check("post_flush_valid", if_valid, 1'b0);
      check("post_flush_count", count, 0);
      step();
      pc_valid = 1'b0;
      @(negedge clk);
      check("squash_valid", if_valid, 1'b0);
      step();
      @(negedge clk);
      check("redirect_valid", if_valid, 1'b1);
      check("redirect_pc", if_pc, 12'h020);
      wait_drain(20);

      // Asynchronous reset in the middle of a cycle with two entries queued.
      step();
      if_ready = 1'b0;
      pc_valid = 1'b1;
      pc_in    = 12'h040;
      step();
      pc_in = 12'h041;
      step();
      pc_valid = 1'b0;
      step();
      @(negedge clk);
      check("pre_reset_count", count, 2);
      step();
      pc_valid = 1'b1;
      pc_in    = 12'h055;
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_valid", if_valid, 1'b0);
      check("async_rst_count", count, 0);
      check("async_rst_imem_en", imem_en, 1'b0);
      pc_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_mid_reset", pc_ready, 1'b1);

      // Push/pop around count=3 across pointer wrap-around.
      step();
      if_ready = 1'b0;
      pc_valid = 1'b1;
      pc_in    = 12'h100;
      step();
      pc_in = 12'h101;
      step();
      pc_in = 12'h102;
      step();
      pc_valid = 1'b0;
      step();
      @(negedge clk);
      check("pre_wrap_count", count, 3);
      step();
      pc_valid = 1'b1;
      if_ready = 1'b1;
      pc_in    = 12'h200;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         acc_now = pc_valid && pc_ready;
         step();
         if (acc_now) pc_in = pc_in + 12'd1;
      end
      pc_valid = 1'b0;
      wait_drain(20);

      // Randomised traffic with stalls and occasional flushes.
      for (int i = 0; i < 400; i++) begin
         step();
         pc_valid = ($urandom_range(0, 3) != 0);
         pc_in    = AW'($urandom());
         if_ready = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 19) == 0);
      end
      step();
      pc_valid = 1'b0;
      flush    = 1'b0;
      if_ready = 1'b1;
      wait_drain(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
